// File: rtl/aemb2_pkg.sv
// Shared constants and decode helper for the AEMB2 control stages.
package aemb2_pkg;

  localparam logic [2:0] MUX_NOP = 3'd0;
  localparam logic [2:0] MUX_RPC = 3'd1;
  localparam logic [2:0] MUX_MEM = 3'd2;
  localparam logic [2:0] MUX_MUL = 3'd3;
  localparam logic [2:0] MUX_BSF = 3'd4;
  localparam logic [2:0] MUX_SFR = 3'd5;
  localparam logic [2:0] MUX_ALU = 3'd7;

  localparam logic [5:0] OPC_NOP  = 6'o42;
  localparam logic [5:0] OPC_MOV  = 6'o45;
  localparam logic [5:0] OPC_MUL0 = 6'o20;
  localparam logic [5:0] OPC_MUL1 = 6'o30;
  localparam logic [5:0] OPC_BSF0 = 6'o21;
  localparam logic [5:0] OPC_BSF1 = 6'o31;
  localparam logic [5:0] OPC_BRU0 = 6'o46;
  localparam logic [5:0] OPC_BRU1 = 6'o56;
  localparam logic [5:0] OPC_BCC0 = 6'o47;
  localparam logic [5:0] OPC_BCC1 = 6'o57;
  localparam logic [5:0] OPC_RTD  = 6'o55;
  localparam logic [5:0] OPC_IMM  = 6'o54;
  localparam logic [5:0] OPC_GET  = 6'o33;

  localparam logic [1:0] BRA_TAKEN_NODLY = 2'b10;

  typedef struct packed {
    logic mov;
    logic mul;
    logic bsf;
    logic bru;
    logic bcc;
    logic rtd;
    logic imm;
    logic lod;
    logic str;
    logic get;
  } dec_t;

  function automatic dec_t decode(input logic [5:0] opc, input logic rb4);
    dec_t d;
    d.mov = (opc == OPC_MOV);
    d.mul = (opc == OPC_MUL0) || (opc == OPC_MUL1);
    d.bsf = (opc == OPC_BSF0) || (opc == OPC_BSF1);
    d.bru = (opc == OPC_BRU0) || (opc == OPC_BRU1);
    d.bcc = (opc == OPC_BCC0) || (opc == OPC_BCC1);
    d.rtd = (opc == OPC_RTD);
    d.imm = (opc == OPC_IMM);
    d.lod = (opc[5:4] == 2'b11) && !opc[2];
    d.str = (opc[5:4] == 2'b11) && opc[2];
    d.get = (opc == OPC_GET) && !rb4;
    return d;
  endfunction

  // Only single-cycle results are available in EX; everything else must wait for MX.
  function automatic logic ex_fwd_ok(input logic [2:0] mux);
    return (mux == MUX_ALU) || (mux == MUX_RPC);
  endfunction

endpackage

// File: rtl/aemb2_fwd_sel.sv
// Thread-tagged operand forward selector: EX has priority over MX, late EX results stall.
module aemb2_fwd_sel
  import aemb2_pkg::*;
#(
  parameter int AEMB_HTX = 2,
  parameter int TW       = 1
) (
  input  logic [4:0]    src_i,
  input  logic          use_i,
  input  logic [TW-1:0] tid_i,
  input  logic [2:0]    mux_ex_i,
  input  logic [4:0]    rd_ex_i,
  input  logic [TW-1:0] tid_ex_i,
  input  logic [31:0]   alu_ex_i,
  input  logic [2:0]    mux_mx_i,
  input  logic [4:0]    rd_mx_i,
  input  logic [TW-1:0] tid_mx_i,
  input  logic [31:0]   res_mx_i,
  output logic          match_o,
  output logic [31:0]   dat_o,
  output logic          stall_o
);

  logic tid_ex_ok;
  logic tid_mx_ok;
  logic ex_hit;
  logic mx_hit;

  generate
    if (AEMB_HTX == 1) begin : g_st
      assign tid_ex_ok = 1'b1;
      assign tid_mx_ok = 1'b1;
    end else begin : g_mt
      assign tid_ex_ok = (tid_ex_i == tid_i);
      assign tid_mx_ok = (tid_mx_i == tid_i);
    end
  endgenerate

  // src != 0 also implies rd != 0, so r0 can never match.
  assign ex_hit = use_i && (src_i != 5'd0) && (src_i == rd_ex_i) &&
                  (mux_ex_i != MUX_NOP) && tid_ex_ok;
  assign mx_hit = use_i && (src_i != 5'd0) && (src_i == rd_mx_i) &&
                  (mux_mx_i != MUX_NOP) && tid_mx_ok;

  always_comb begin
    match_o = 1'b0;
    dat_o   = 32'd0;
    stall_o = 1'b0;
    if (ex_hit) begin
      if (ex_fwd_ok(mux_ex_i)) begin
        match_o = 1'b1;
        dat_o   = alu_ex_i;
      end else begin
        stall_o = 1'b1;
      end
    end else if (mx_hit) begin
      match_o = 1'b1;
      dat_o   = res_mx_i;
    end
  end

endmodule

// File: rtl/aemb2_ctrl_mt.sv
// Multithreaded decode / operand-control stage between IF and EX of the AEMB2 pipeline.
// Per-thread IMM prefix, tagged EX/MX forwarding, branch-flush and load-use bubbles.
module aemb2_ctrl_mt
  import aemb2_pkg::*;
#(
  parameter int AEMB_HTX = 2,
  parameter int TW       = (AEMB_HTX > 1) ? $clog2(AEMB_HTX) : 1
) (
  input  logic          gclk,
  input  logic          grst_n,
  input  logic          dena,
  input  logic [TW-1:0] gtid,
  input  logic [31:0]   ich_dat,
  input  logic [29:0]   rpc_if,
  input  logic [31:0]   opa_if,
  input  logic [31:0]   opb_if,
  input  logic [31:0]   opd_if,
  input  logic [31:0]   alu_ex,
  input  logic [31:0]   res_mx,
  input  logic [1:0]    bra_ex,
  output logic [31:0]   opa_of,
  output logic [31:0]   opb_of,
  output logic [31:0]   opd_of,
  output logic [5:0]    opc_of,
  output logic [4:0]    ra_of,
  output logic [4:0]    rd_of,
  output logic [15:0]   imm_of,
  output logic [TW-1:0] tid_of,
  output logic [2:0]    mux_of,
  output logic [2:0]    mux_ex,
  output logic [2:0]    mux_mx,
  output logic [4:0]    rd_ex,
  output logic [4:0]    rd_mx,
  output logic [TW-1:0] tid_ex,
  output logic [TW-1:0] tid_mx,
  output logic          hzd_bpc,
  output logic          hzd_fwd
);

  logic [5:0]  opc_if;
  logic [4:0]  rd_if;
  logic [4:0]  ra_if;
  logic [4:0]  rb_if;
  logic [15:0] imm_raw;
  dec_t        dec;

  assign opc_if  = ich_dat[31:26];
  assign rd_if   = ich_dat[25:21];
  assign ra_if   = ich_dat[20:16];
  assign imm_raw = ich_dat[15:0];
  assign rb_if   = ich_dat[15:11];
  assign dec     = decode(opc_if, rb_if[4]);

  logic [31:0]   opa_of_q, opb_of_q, opd_of_q;
  logic [5:0]    opc_of_q;
  logic [4:0]    ra_of_q, rd_of_q, rd_ex_q, rd_mx_q;
  logic [15:0]   imm_of_q;
  logic [TW-1:0] tid_of_q, tid_ex_q, tid_mx_q;
  logic [2:0]    mux_of_q, mux_ex_q, mux_mx_q;

  logic          hzd;
  logic [AEMB_HTX-1:0] thr_sel;
  logic [AEMB_HTX-1:0] imm_flag;
  logic [15:0]   imm_val [AEMB_HTX];
  logic          cur_flag;
  logic [15:0]   cur_val;
  logic [31:0]   imm_if;

  // One IMM-prefix slot per hardware thread.
  generate
    for (genvar gi = 0; gi < AEMB_HTX; gi++) begin : g_thr
      logic        flag_q, flag_d;
      logic [15:0] val_q;

      if (AEMB_HTX == 1) begin : g_one
        assign thr_sel[gi] = 1'b1;
      end else begin : g_many
        assign thr_sel[gi] = (gtid == TW'(gi));
      end

      // A stalled instruction keeps the prefix so its retry still sees it.
      always_comb begin
        flag_d = flag_q;
        if (thr_sel[gi]) begin
          if (hzd_bpc)       flag_d = 1'b0;
          else if (dec.imm)  flag_d = 1'b1;
          else if (!hzd_fwd) flag_d = 1'b0;
        end
      end

      always_ff @(posedge gclk) begin
        if (!grst_n)   flag_q <= 1'b0;
        else if (dena) flag_q <= flag_d;
      end

      always_ff @(posedge gclk) begin
        if (dena && thr_sel[gi] && dec.imm && !hzd_bpc) val_q <= imm_raw;
      end

      assign imm_flag[gi] = flag_q;
      assign imm_val[gi]  = val_q;
    end
  endgenerate

  always_comb begin
    cur_flag = 1'b0;
    cur_val  = 16'd0;
    for (int i = 0; i < AEMB_HTX; i++) begin
      if (thr_sel[i]) begin
        cur_flag = imm_flag[i];
        cur_val  = imm_val[i];
      end
    end
  end

  assign imm_if = {cur_flag ? cur_val : {16{imm_raw[15]}}, imm_raw};

  logic        use_a, use_b, use_d;
  logic [4:0]  src_d;
  logic        fa_match, fb_match, fd_match;
  logic [31:0] fa_dat, fb_dat, fd_dat;
  logic        fa_stall, fb_stall, fd_stall;

  assign use_a = !(dec.bru || dec.bcc);
  assign use_b = !opc_if[3];
  assign use_d = dec.str || dec.bcc;
  assign src_d = dec.bcc ? ra_if : rd_if;

  aemb2_fwd_sel #(.AEMB_HTX(AEMB_HTX), .TW(TW)) u_fwd_a (
    .src_i(ra_if), .use_i(use_a), .tid_i(gtid),
    .mux_ex_i(mux_ex_q), .rd_ex_i(rd_ex_q), .tid_ex_i(tid_ex_q), .alu_ex_i(alu_ex),
    .mux_mx_i(mux_mx_q), .rd_mx_i(rd_mx_q), .tid_mx_i(tid_mx_q), .res_mx_i(res_mx),
    .match_o(fa_match), .dat_o(fa_dat), .stall_o(fa_stall)
  );

  aemb2_fwd_sel #(.AEMB_HTX(AEMB_HTX), .TW(TW)) u_fwd_b (
    .src_i(rb_if), .use_i(use_b), .tid_i(gtid),
    .mux_ex_i(mux_ex_q), .rd_ex_i(rd_ex_q), .tid_ex_i(tid_ex_q), .alu_ex_i(alu_ex),
    .mux_mx_i(mux_mx_q), .rd_mx_i(rd_mx_q), .tid_mx_i(tid_mx_q), .res_mx_i(res_mx),
    .match_o(fb_match), .dat_o(fb_dat), .stall_o(fb_stall)
  );

  aemb2_fwd_sel #(.AEMB_HTX(AEMB_HTX), .TW(TW)) u_fwd_d (
    .src_i(src_d), .use_i(use_d), .tid_i(gtid),
    .mux_ex_i(mux_ex_q), .rd_ex_i(rd_ex_q), .tid_ex_i(tid_ex_q), .alu_ex_i(alu_ex),
    .mux_mx_i(mux_mx_q), .rd_mx_i(rd_mx_q), .tid_mx_i(tid_mx_q), .res_mx_i(res_mx),
    .match_o(fd_match), .dat_o(fd_dat), .stall_o(fd_stall)
  );

  generate
    if (AEMB_HTX == 1) begin : g_bpc_st
      assign hzd_bpc = (bra_ex == BRA_TAKEN_NODLY);
    end else begin : g_bpc_mt
      assign hzd_bpc = (bra_ex == BRA_TAKEN_NODLY) && (tid_ex_q == gtid);
    end
  endgenerate

  assign hzd_fwd = fa_stall || fb_stall || fd_stall;
  assign hzd     = hzd_bpc || hzd_fwd;

  logic [31:0] opa_d, opb_d, opd_d;
  logic [5:0]  opc_d;
  logic [2:0]  mux_d;

  always_comb begin
    opa_d = (dec.bru || dec.bcc) ? {rpc_if, 2'b00} : (fa_match ? fa_dat : opa_if);
    opb_d = opc_if[3] ? imm_if : (fb_match ? fb_dat : opb_if);
    opd_d = fd_match ? fd_dat : (dec.bcc ? opa_if : opd_if);
    opc_d = hzd ? OPC_NOP : opc_if;
    mux_d = MUX_NOP;
    if (hzd)                             mux_d = MUX_NOP;
    else if (dec.mov)                    mux_d = MUX_SFR;
    else if (dec.mul)                    mux_d = MUX_MUL;
    else if (dec.bsf)                    mux_d = MUX_BSF;
    else if (dec.lod || dec.get)         mux_d = MUX_MEM;
    else if (dec.bru)                    mux_d = MUX_RPC;
    else if (dec.str || dec.rtd || dec.bcc) mux_d = MUX_NOP;
    else if (rd_if != 5'd0)              mux_d = MUX_ALU;
  end

  always_ff @(posedge gclk) begin
    if (!grst_n) begin
      opa_of_q <= '0; opb_of_q <= '0; opd_of_q <= '0;
      opc_of_q <= '0; ra_of_q  <= '0; rd_of_q  <= '0;
      imm_of_q <= '0; tid_of_q <= '0; mux_of_q <= '0;
      mux_ex_q <= '0; rd_ex_q  <= '0; tid_ex_q <= '0;
      mux_mx_q <= '0; rd_mx_q  <= '0; tid_mx_q <= '0;
    end else if (dena) begin
      opa_of_q <= opa_d;
      opb_of_q <= opb_d;
      opd_of_q <= opd_d;
      opc_of_q <= opc_d;
      ra_of_q  <= ra_if;
      rd_of_q  <= rd_if;
      imm_of_q <= imm_raw;
      tid_of_q <= gtid;
      mux_of_q <= mux_d;
      mux_ex_q <= mux_of_q;
      rd_ex_q  <= rd_of_q;
      tid_ex_q <= tid_of_q;
      mux_mx_q <= mux_ex_q;
      rd_mx_q  <= rd_ex_q;
      tid_mx_q <= tid_ex_q;
    end
  end

  assign opa_of = opa_of_q;
  assign opb_of = opb_of_q;
  assign opd_of = opd_of_q;
  assign opc_of = opc_of_q;
  assign ra_of  = ra_of_q;
  assign rd_of  = rd_of_q;
  assign imm_of = imm_of_q;
  assign tid_of = tid_of_q;
  assign mux_of = mux_of_q;
  assign mux_ex = mux_ex_q;
  assign rd_ex  = rd_ex_q;
  assign tid_ex = tid_ex_q;
  assign mux_mx = mux_mx_q;
  assign rd_mx  = rd_mx_q;
  assign tid_mx = tid_mx_q;

endmodule

// File: doc/aemb2_ctrl_mt.md
# aemb2_ctrl_mt

Parametrised multithreaded instruction decode and operand-control stage for the AEMB2 pipeline, sitting between instruction fetch (IF) and execute (EX). It generalises the two-phase decoder to `AEMB_HTX` interleaved hardware threads. Each thread has its own IMM-prefix state. Operands are forwarded from both the EX and MX stages with thread-tag matching. Branch flush and load-use bubbles are generated per thread.

## Interface
- `AEMB_HTX`, default 2: number of hardware threads. Legal values are 1, 2 and 4.
- `TW`, default `$clog2(AEMB_HTX)` (minimum 1): thread-id width.
- `gclk`  in  1  pipeline clock; all state changes on rising edge.
- `grst_n`  in  1  reset, synchronous, active-low.
- `dena`  in  1  pipeline advance enable. When low, all state holds.
- `gtid`  in  TW  thread id of the instruction presented in IF.
- `ich_dat`  in  32  fetched instruction, laid out as {opc[5:0], rd[4:0], ra[4:0], imm[15:0]}; rb = imm[15:11].
- `rpc_if`  in  30  PC[31:2] of the IF instruction.
- `opa_if`, `opb_if`, `opd_if`  in  32 each  register-file read data.
- `alu_ex`  in  32  EX single-cycle result.
- `res_mx`  in  32  MX final result, valid for any writeback op.
- `bra_ex`  in  2  EX branch status; 2'b10 means taken with no delay slot.
- `opa_of`, `opb_of`, `opd_of`  out  32 each  latched operands.
- `opc_of`  out  6  opcode, or 6'o42 when the slot is a bubble.
- `ra_of`, `rd_of`  out  5 each  register fields.
- `imm_of`  out  16  immediate field.
- `tid_of`  out  TW  thread id of the OF slot.
- `mux_of`, `mux_ex`, `mux_mx`  out  3 each  writeback select per stage.
- `rd_ex`, `rd_mx`  out  5 each  destination tags for the EX and MX stages.
- `tid_ex`, `tid_mx`  out  TW each  thread tags for the EX and MX stages.
- `hzd_bpc`  out  1  branch flush of the IF slot (combinational).
- `hzd_fwd`  out  1  load-use stall and bubble (combinational).

## Operation
- **Decode groups:**
  - MOV: opc 6'o45
  - MUL: 6'o20 or 6'o30
  - BSF: 6'o21 or 6'o31
  - BRU: 6'o46 or 6'o56
  - BCC: 6'o47 or 6'o57
  - RTD: 6'o55
  - IMM: 6'o54
  - LOD: opc[5:4]=3, opc[2]=0
  - STR: opc[5:4]=3, opc[2]=1
  - GET: opc 6'o33 with rb[4]=0
- **mux_of priority** (first match wins):
  1. hazard → NOP(0)
  2. MOV → SFR(5)
  3. MUL → MUL(3)
  4. BSF → BSF(4)
  5. LOD or GET → MEM(2)
  6. BRU → RPC(1)
  7. STR, RTD or BCC → NOP
  8. rd≠0 → ALU(7)
  9. otherwise NOP
- **Pipeline tags:** on each `dena` edge, {mux, rd, tid} shift OF→EX→MX.
  - A stage "writes" when mux≠0 and rd≠0.
- **IMM prefix:** one flag plus a 16-bit value per thread, indexed by `gtid`.
  - An IMM instruction sets flag[gtid] and stores the value, unless `hzd_bpc`.
  - Any other accepted instruction of that thread clears flag[gtid].
  - `imm_if` = {flag ? value : sign-extend(imm[15]), imm}.
- **Forward match** for source s (ra, rb, or rd for STR/ra for BCC): s == rd_stage AND tid_stage == `gtid` AND the stage writes.
  - EX has priority over MX.
  - EX source is `alu_ex`; MX source is `res_mx`.
  - r0 never matches.
- **EX match eligibility:** if mux_ex is ALU or RPC, forward `alu_ex`. If mux_ex is MEM, MUL, BSF or SFR, raise `hzd_fwd`.
- **Operand selection:**
  - opa: `{rpc_if, 2'b00}` for BRU or BCC; otherwise forwarded value or `opa_if`.
  - opb: `imm_if` when opc[3]=1; otherwise forwarded value or `opb_if`.
  - opd: forwarded value if matched; else `opa_if` for BCC, else `opd_if`.
- **Branch flush:** `hzd_bpc` = (bra_ex == 2'b10) AND (tid_ex == gtid).
- **Bubble:** on `hzd_bpc` or `hzd_fwd`, the slot latches mux NOP and opc 6'o42. Operand and field registers still load.

## Timing
- Decode latency is 1 cycle: the IF instruction appears on the `*_of` outputs after the next `dena` edge.
- `hzd_*` are combinational from the IF inputs and EX tags in the same cycle. Fetch must hold on `hzd_fwd`.
- The bubble clears the EX stall one cycle later, once the producer reaches MX and the operand comes from `res_mx`.
- **Reset (`grst_n`=0 at an edge):**
  - All outputs clear to 0, all IMM flags clear, and all tags clear. Reset overrides `dena`.
  - Reset mid-stream discards any pending prefix.
- **Simultaneous hazards:** `hzd_bpc` together with `hzd_fwd` produces a single bubble. The IMM flag of that thread clears.
- With `AEMB_HTX`=1, the thread-tag compare is constant-true and `gtid` is ignored.

## Structure
- Shared package `aemb2_pkg`:
  - MUX_* localparams: ALU 7, SFR 5, BSF 4, MUL 3, MEM 2, RPC 1, NOP 0
  - OPC_NOP = 6'o42
  - opcode constants for the groups above
- Sub-module `aemb2_fwd_sel`, instantiated three times (opa, opb, opd). It takes the source, a use-enable, and the EX/MX tags and data. It returns a match flag, the forwarded data, and a stall request.

## Test plan
- **Reset:** hold `grst_n`=0 for 2 cycles with `dena`=1 → every output is 0. IMM r1, 0x1234 then ADDI → `opb_of` = 0xFFFF_xxxx sign-extended, not 0x1234.
- **EX forward:** thread 0 `add r3,r1,r2`, then thread 0 `add r4,r3,r3` → `opa_of` = `opb_of` = `alu_ex`, `hzd_fwd`=0.
- **Load-use:** `lw r5`, then a consumer of r5 in the same thread → `hzd_fwd`=1 for one cycle, bubble opc 6'o42. The retried instruction then takes `res_mx`.
- **Cross-thread isolation:** `AEMB_HTX`=2, thread 1 writes r5 while thread 0 reads r5 → no forward; `opa_of` = `opa_if`.
- **Per-thread IMM:** thread 0 IMM 0xDEAD, thread 1 ADDI 0x8000, thread 0 ADDI 0xBEEF → thread 1 `opb_of` = 0xFFFF8000; thread 0 `opb_of` = 0xDEADBEEF.
- **Flush:** `bra_ex`=2'b10 with `tid_ex`=`gtid`, while the IF slot holds IMM 0x1 → `hzd_bpc`=1, slot bubbled, flag stays clear. The next ADDI -1 yields 0xFFFFFFFF.
